nes_pad_poll_sched: RTL and testbench



---
 rtl/nes_pad_pkg.sv | 49 ++++
 rtl/nes_tick_gen.sv | 33 +++
 rtl/nes_pad_poll_sched.sv | 183 ++++++++++++++++++
 tb/tb_nes_pad_poll_sched.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES pad poller: sequencer states, button bit
// positions and the Konami-style masks consumed by the easter-egg FSM.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StLow,
    StHigh,
    StGap
  } pad_state_e;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam logic [7:0] MASK_A      = 8'h01 << BTN_A;
  localparam logic [7:0] MASK_B      = 8'h01 << BTN_B;
  localparam logic [7:0] MASK_START  = 8'h01 << BTN_START;
  localparam logic [7:0] MASK_UP     = 8'h01 << BTN_UP;
  localparam logic [7:0] MASK_DOWN   = 8'h01 << BTN_DOWN;
  localparam logic [7:0] MASK_LEFT   = 8'h01 << BTN_LEFT;
  localparam logic [7:0] MASK_RIGHT  = 8'h01 << BTN_RIGHT;

  localparam int unsigned KONAMI_LEN = 11;

  // Up Up Down Down Left Right Left Right B A Start.
  function automatic logic [7:0] konami_step(int unsigned step);
    logic [7:0] mask;
    mask = '0;
    case (step)
      0, 1:    mask = MASK_UP;
      2, 3:    mask = MASK_DOWN;
      4, 6:    mask = MASK_LEFT;
      5, 7:    mask = MASK_RIGHT;
      8:       mask = MASK_B;
      9:       mask = MASK_A;
      10:      mask = MASK_START;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/nes_tick_gen.sv
// Interface tick prescaler: one-cycle tick every CLK_DIV clocks, restartable
// by a synchronous clear so each frame starts on a fresh tick boundary.
module nes_tick_gen #(
  parameter int unsigned CLK_DIV = 256
) (
  input  logic clk_old,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_old) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nes_pad_poll_sched.sv
// Two-pad NES serial poller: drives shared latch/pulse, shifts both data lines
// and publishes button words plus pressed-edge flags once per frame.
module nes_pad_poll_sched
  import nes_pad_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 256,
  parameter int unsigned LATCH_TICKS = 2,
  parameter int unsigned NUM_BITS    = 8,
  parameter int unsigned FRAME_TICKS = 1634
) (
  input  logic                clk_old,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                poll_req,
  input  logic                data_a,
  input  logic                data_b,
  output logic                latch,
  output logic                pulse,
  output logic                busy,
  output logic [NUM_BITS-1:0] btn_a,
  output logic [NUM_BITS-1:0] btn_b,
  output logic [NUM_BITS-1:0] press_a,
  output logic [NUM_BITS-1:0] press_b,
  output logic                frame_valid
);

  localparam int unsigned FcW = $clog2(FRAME_TICKS);
  localparam int unsigned PcW = $clog2(NUM_BITS + 1);

  pad_state_e          state_q, state_d;
  logic [FcW-1:0]      fc_q, fc_d;
  logic [PcW-1:0]      pulse_cnt_q, pulse_cnt_d;
  logic [PcW-1:0]      sample_idx;
  logic [NUM_BITS-1:0] shadow_a_q, shadow_a_d, shadow_b_q, shadow_b_d;
  logic [NUM_BITS-1:0] btn_a_q, btn_a_d, btn_b_q, btn_b_d;
  logic [NUM_BITS-1:0] press_a_q, press_a_d, press_b_q, press_b_d;
  logic                pending_q, pending_d;
  logic                latch_q, latch_d, pulse_q, pulse_d, fv_q, fv_d;
  logic                tick, start, commit, sample_en;

  nes_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk_old(clk_old),
    .reset_n(reset_n),
    .clear  (start),
    .tick   (tick)
  );

  assign busy = (state_q == StLatch) || (state_q == StLow) || (state_q == StHigh);

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    sample_en   = 1'b0;
    sample_idx  = pulse_cnt_q;
    commit      = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable || poll_req || pending_q) state_d = StLatch;
      end
      StLatch: begin
        if (tick && (fc_q == FcW'(LATCH_TICKS - 1))) begin
          sample_en  = 1'b1;
          sample_idx = '0;
          state_d    = StLow;
        end
      end
      StLow: begin
        // The LOW right after the latch has nothing new to read: bit 0 was
        // taken at latch end, bit k appears only after the k-th pulse.
        if (tick) begin
          sample_en = (pulse_cnt_q != '0);
          state_d   = StHigh;
        end
      end
      StHigh: begin
        if (tick) begin
          pulse_cnt_d = pulse_cnt_q + PcW'(1);
          if (pulse_cnt_d == PcW'(NUM_BITS)) begin
            state_d = StGap;
            commit  = 1'b1;
          end else begin
            state_d = StLow;
          end
        end
      end
      StGap: begin
        if (poll_req || pending_q) begin
          state_d = StLatch;
        end else if (!enable) begin
          state_d = StIdle;
        end else if (tick && (fc_q == FcW'(FRAME_TICKS - 1))) begin
          state_d = StLatch;
        end
      end
      default: state_d = StIdle;
    endcase
    start = (state_d == StLatch) && (state_q != StLatch);
    if (start) pulse_cnt_d = '0;
  end

  always_comb begin
    fc_d = fc_q;
    if (start) begin
      fc_d = '0;
    end else if (tick && (state_q != StIdle)) begin
      fc_d = fc_q + FcW'(1);
    end

    pending_d = pending_q;
    if (start) begin
      pending_d = 1'b0;
    end else if (busy && poll_req) begin
      pending_d = 1'b1;
    end

    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    for (int unsigned i = 0; i < NUM_BITS; i++) begin
      if (sample_en && (sample_idx == PcW'(i))) begin
        shadow_a_d[i] = data_a;
        shadow_b_d[i] = data_b;
      end
    end

    btn_a_d   = btn_a_q;
    btn_b_d   = btn_b_q;
    press_a_d = press_a_q;
    press_b_d = press_b_q;
    if (commit) begin
      btn_a_d   = ~shadow_a_q;
      btn_b_d   = ~shadow_b_q;
      press_a_d = ~shadow_a_q & ~btn_a_q;
      press_b_d = ~shadow_b_q & ~btn_b_q;
    end

    latch_d = (state_d == StLatch);
    pulse_d = (state_d == StHigh);
    fv_d    = commit;
  end

  always_ff @(posedge clk_old) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      fc_q        <= '0;
      pulse_cnt_q <= '0;
      pending_q   <= 1'b0;
      shadow_a_q  <= '0;
      shadow_b_q  <= '0;
      btn_a_q     <= '0;
      btn_b_q     <= '0;
      press_a_q   <= '0;
      press_b_q   <= '0;
      latch_q     <= 1'b0;
      pulse_q     <= 1'b0;
      fv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      fc_q        <= fc_d;
      pulse_cnt_q <= pulse_cnt_d;
      pending_q   <= pending_d;
      shadow_a_q  <= shadow_a_d;
      shadow_b_q  <= shadow_b_d;
      btn_a_q     <= btn_a_d;
      btn_b_q     <= btn_b_d;
      press_a_q   <= press_a_d;
      press_b_q   <= press_b_d;
      latch_q     <= latch_d;
      pulse_q     <= pulse_d;
      fv_q        <= fv_d;
    end
  end

  assign latch       = latch_q;
  assign pulse       = pulse_q;
  assign frame_valid = fv_q;
  assign btn_a       = btn_a_q;
  assign btn_b       = btn_b_q;
  assign press_a     = press_a_q;
  assign press_b     = press_b_q;

endmodule

// File: tb/tb_nes_pad_poll_sched.sv
// Bench for nes_pad_poll_sched: behavioural pad models on both data lines and
// frame timing/button expectations computed from the interface rules.
module tb_nes_pad_poll_sched;

  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned LATCH_TICKS = 2;
  localparam int unsigned NUM_BITS    = 8;
  localparam int unsigned FRAME_TICKS = 24;
  localparam int FRAME_CLKS  = (LATCH_TICKS + 2 * NUM_BITS) * CLK_DIV;  // 72
  localparam int PERIOD_CLKS = FRAME_TICKS * CLK_DIV;                   // 96

  logic       clk_old  = 1'b0;
  logic       reset_n  = 1'b0;
  logic       enable   = 1'b0;
  logic       poll_req = 1'b0;
  logic       data_a   = 1'b1;
  logic       data_b   = 1'b1;
  logic       latch, pulse, busy, frame_valid;
  logic [7:0] btn_a, btn_b, press_a, press_b;

  int         checks = 0;
  int         errors = 0;

  // Buttons held on each pad, active-high (bit i = i-th shifted button).
  logic [7:0] pat_a = 8'h00;
  logic [7:0] pat_b = 8'h00;
  int         pad_k = 8;
  logic       prev_pulse = 1'b0;

  nes_pad_poll_sched #(
    .CLK_DIV    (CLK_DIV),
    .LATCH_TICKS(LATCH_TICKS),
    .NUM_BITS   (NUM_BITS),
    .FRAME_TICKS(FRAME_TICKS)
  ) dut (
    .clk_old    (clk_old),
    .reset_n    (reset_n),
    .enable     (enable),
    .poll_req   (poll_req),
    .data_a     (data_a),
    .data_b     (data_b),
    .latch      (latch),
    .pulse      (pulse),
    .busy       (busy),
    .btn_a      (btn_a),
    .btn_b      (btn_b),
    .press_a    (press_a),
    .press_b    (press_b),
    .frame_valid(frame_valid)
  );

  initial forever #5 clk_old = ~clk_old;

  // 4021-style pad: latch loads button 0, each pulse rise shifts the next one out.
  always @(negedge clk_old) begin
    if (latch) pad_k = 0;
    else if (pulse && !prev_pulse) pad_k = pad_k + 1;
    prev_pulse = pulse;
    data_a = (pad_k < 8) ? ~pat_a[pad_k] : 1'b1;
    data_b = (pad_k < 8) ? ~pat_b[pad_k] : 1'b1;
  end

  // Expected interface levels r clocks into a frame (r = 1 is the latch rise).
  function automatic bit exp_latch(int r);
    return (r >= 1) && (r <= int'(LATCH_TICKS * CLK_DIV));
  endfunction

  function automatic bit exp_pulse(int r);
    int first;
    first = int'((LATCH_TICKS + 1) * CLK_DIV) + 1;
    return (r >= first) && (r <= FRAME_CLKS) && (((r - first) % int'(2 * CLK_DIV)) < int'(CLK_DIV));
  endfunction

  function automatic bit exp_busy(int r);
    return (r >= 1) && (r <= FRAME_CLKS);
  endfunction

  function automatic bit exp_fv(int r);
    return r == FRAME_CLKS + 1;
  endfunction

  task automatic do_reset();
    reset_n  = 1'b0;
    enable   = 1'b0;
    poll_req = 1'b0;
    repeat (3) @(negedge clk_old);
  endtask

  task automatic wait_fv(input int budget, output bit seen, output int waited);
    seen   = 1'b0;
    waited = 0;
    while (!seen && (waited < budget)) begin
      @(negedge clk_old);
      waited++;
      if (frame_valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({latch, pulse, busy, frame_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000", {latch, pulse, busy, frame_valid});
    end
    checks++;
    if ({btn_a, btn_b, press_a, press_b} !== 32'h0) begin
      errors++;
      $display("FAIL reset_words: got %h want 00000000", {btn_a, btn_b, press_a, press_b});
    end
  endtask

  task automatic test_periodic();
    logic [3:0] exp_w;
    int         r;
    pat_a   = 8'h00;
    pat_b   = 8'h00;
    reset_n = 1'b1;
    enable  = 1'b1;
    for (int rel = 1; rel <= PERIOD_CLKS + int'(LATCH_TICKS * CLK_DIV); rel++) begin
      @(negedge clk_old);
      r = (rel > PERIOD_CLKS) ? rel - PERIOD_CLKS : rel;
      exp_w = {exp_latch(r), exp_pulse(r), exp_busy(r), exp_fv(r)};
      checks++;
      if ({latch, pulse, busy, frame_valid} !== exp_w) begin
        errors++;
        $display("FAIL periodic_wave rel=%0d: got %b want %b", rel,
                 {latch, pulse, busy, frame_valid}, exp_w);
      end
      if (rel == FRAME_CLKS + 1) begin
        checks++;
        if ({btn_a, btn_b, press_a, press_b} !== 32'h0) begin
          errors++;
          $display("FAIL periodic_words: got %h want 00000000", {btn_a, btn_b, press_a, press_b});
        end
      end
    end
  endtask

  task automatic test_buttons();
    bit seen;
    int waited;
    do_reset();
    pat_a   = 8'h81;
    pat_b   = 8'h08;
    reset_n = 1'b1;
    enable  = 1'b1;
    wait_fv(200, seen, waited);
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL buttons_fv1: no frame_valid within %0d clocks", waited);
    end
    checks++;
    if ({btn_a, btn_b, press_a, press_b} !== 32'h8108_8108) begin
      errors++;
      $display("FAIL buttons_first: got %h want 81088108", {btn_a, btn_b, press_a, press_b});
    end
    @(negedge clk_old);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL buttons_strobe_width: frame_valid %b want 0", frame_valid);
    end
    wait_fv(200, seen, waited);
    checks++;
    if (!seen || (waited != PERIOD_CLKS - 1)) begin
      errors++;
      $display("FAIL buttons_fv2: seen=%0d after %0d want %0d", seen, waited, PERIOD_CLKS - 1);
    end
    checks++;
    if ({btn_a, btn_b, press_a, press_b} !== 32'h8108_0000) begin
      errors++;
      $display("FAIL buttons_repeat: got %h want 81080000", {btn_a, btn_b, press_a, press_b});
    end
  endtask

  // Continues from test_buttons: enable stays high, one new pattern per frame.
  task automatic test_random_frames();
    logic [7:0] prev_a, prev_b, exp_pa, exp_pb;
    bit         seen;
    int         waited;
    prev_a = 8'h81;
    prev_b = 8'h08;
    for (int i = 0; i < 6; i++) begin
      pat_a = (i == 0) ? 8'hFF : 8'($urandom);
      pat_b = (i == 1) ? 8'h00 : 8'($urandom);
      wait_fv(PERIOD_CLKS + 20, seen, waited);
      checks++;
      if (!seen || (waited != PERIOD_CLKS)) begin
        errors++;
        $display("FAIL random_period[%0d]: seen=%0d after %0d want %0d", i, seen, waited,
                 PERIOD_CLKS);
      end
      exp_pa = pat_a & ~prev_a;
      exp_pb = pat_b & ~prev_b;
      checks++;
      if ({btn_a, btn_b, press_a, press_b} !== {pat_a, pat_b, exp_pa, exp_pb}) begin
        errors++;
        $display("FAIL random_words[%0d]: got %h want %h", i, {btn_a, btn_b, press_a, press_b},
                 {pat_a, pat_b, exp_pa, exp_pb});
      end
      prev_a = pat_a;
      prev_b = pat_b;
    end
  endtask

  task automatic test_single_poll();
    int         busy_cnt, first_busy, fv_cnt, fv_rel, rise_cnt, late_act;
    logic       prev_l;
    logic [7:0] got_a, got_pa;
    do_reset();
    reset_n = 1'b1;
    repeat (5) @(negedge clk_old);
    checks++;
    if ({latch, busy} !== 2'b00) begin
      errors++;
      $display("FAIL poll_idle: latch/busy %b want 00", {latch, busy});
    end
    pat_a = 8'($urandom);
    pat_b = 8'($urandom);
    busy_cnt = 0; first_busy = -1; fv_cnt = 0; fv_rel = -1; rise_cnt = 0; late_act = 0;
    prev_l = 1'b0; got_a = '0; got_pa = '0;
    poll_req = 1'b1;
    for (int rel = 1; rel <= 300; rel++) begin
      @(negedge clk_old);
      poll_req = 1'b0;
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = rel;
      end
      if (frame_valid) begin
        fv_cnt++;
        fv_rel = rel;
        got_a  = btn_a;
        got_pa = press_a;
      end
      if (latch && !prev_l) rise_cnt++;
      prev_l = latch;
      if ((rel > FRAME_CLKS) && (latch || pulse)) late_act++;
    end
    checks++;
    if ((busy_cnt != FRAME_CLKS) || (first_busy != 1)) begin
      errors++;
      $display("FAIL poll_busy: %0d clocks from %0d want %0d from 1", busy_cnt, first_busy,
               FRAME_CLKS);
    end
    checks++;
    if ((fv_cnt != 1) || (fv_rel != FRAME_CLKS + 1) || (rise_cnt != 1)) begin
      errors++;
      $display("FAIL poll_once: fv=%0d at %0d rises=%0d want 1 at %0d rises=1", fv_cnt, fv_rel,
               rise_cnt, FRAME_CLKS + 1);
    end
    checks++;
    if (late_act != 0) begin
      errors++;
      $display("FAIL poll_quiet: %0d active clocks after frame want 0", late_act);
    end
    checks++;
    if ({got_a, got_pa} !== {pat_a, pat_a}) begin
      errors++;
      $display("FAIL poll_words: got %h want %h", {got_a, got_pa}, {pat_a, pat_a});
    end
  endtask

  task automatic test_poll_mid_frame();
    int   rises[$];
    int   fvs[$];
    logic prev_l;
    do_reset();
    pat_a   = 8'($urandom);
    pat_b   = 8'($urandom);
    reset_n = 1'b1;
    enable  = 1'b1;
    prev_l  = 1'b0;
    for (int rel = 1; rel <= 180; rel++) begin
      @(negedge clk_old);
      // rel 30: inside pulse 3 high; rel 45: inside pulse 5 high.
      poll_req = (rel == 30) || (rel == 45);
      if (latch && !prev_l) rises.push_back(rel);
      prev_l = latch;
      if (frame_valid) fvs.push_back(rel);
    end
    poll_req = 1'b0;
    checks++;
    if ((rises.size() != 3) || (rises[0] != 1) || (rises[1] != FRAME_CLKS + 2) ||
        (rises[2] != FRAME_CLKS + 2 + PERIOD_CLKS)) begin
      errors++;
      $display("FAIL ondemand_rises: got %p want '{1, %0d, %0d}", rises, FRAME_CLKS + 2,
               FRAME_CLKS + 2 + PERIOD_CLKS);
    end
    checks++;
    if ((fvs.size() != 2) || (fvs[0] != FRAME_CLKS + 1) || (fvs[1] != 2 * FRAME_CLKS + 2)) begin
      errors++;
      $display("FAIL ondemand_commits: got %p want '{%0d, %0d}", fvs, FRAME_CLKS + 1,
               2 * FRAME_CLKS + 2);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit         seen;
    int         waited, bad, fv_early, fv_rel;
    logic [3:0] exp_w;
    logic [7:0] got_a, got_pa;
    do_reset();
    pat_a   = 8'($urandom) | 8'h01;
    pat_b   = 8'($urandom) | 8'h80;
    reset_n = 1'b1;
    enable  = 1'b1;
    wait_fv(200, seen, waited);
    checks++;
    if (!seen || (btn_a !== pat_a)) begin
      errors++;
      $display("FAIL rst_pre_frame: seen=%0d btn_a=%h want %h", seen, btn_a, pat_a);
    end
    // Now at frame-1 commit; pulse 5 of frame 2 is high at rel 141..144.
    for (int rel = FRAME_CLKS + 2; rel <= PERIOD_CLKS + 46; rel++) @(negedge clk_old);
    reset_n = 1'b0;
    @(negedge clk_old);
    checks++;
    if ({latch, pulse, busy, frame_valid, btn_a, btn_b, press_a, press_b} !== 36'h0) begin
      errors++;
      $display("FAIL rst_mid_clear: ctrl=%b words=%h want all zero",
               {latch, pulse, busy, frame_valid}, {btn_a, btn_b, press_a, press_b});
    end
    reset_n = 1'b1;
    bad = 0; fv_early = 0; fv_rel = -1; got_a = '0; got_pa = '0;
    for (int rel = 1; rel <= FRAME_CLKS + 1; rel++) begin
      @(negedge clk_old);
      exp_w = {exp_latch(rel), exp_pulse(rel), exp_busy(rel), exp_fv(rel)};
      if ({latch, pulse, busy, frame_valid} !== exp_w) bad++;
      if (frame_valid && (rel <= FRAME_CLKS)) fv_early++;
      if (frame_valid) begin
        fv_rel = rel;
        got_a  = btn_a;
        got_pa = press_a;
      end
    end
    checks++;
    if ((bad != 0) || (fv_early != 0)) begin
      errors++;
      $display("FAIL rst_restart_wave: %0d bad clocks, %0d early strobes want 0/0", bad, fv_early);
    end
    checks++;
    if ((fv_rel != FRAME_CLKS + 1) || ({got_a, got_pa} !== {pat_a, pat_a})) begin
      errors++;
      $display("FAIL rst_restart_words: fv at %0d words %h want %0d %h", fv_rel, {got_a, got_pa},
               FRAME_CLKS + 1, {pat_a, pat_a});
    end
  endtask

  task automatic test_enable_drop();
    int         fv_cnt, fv_rel, rise_cnt, busy_cnt;
    logic       prev_l;
    logic [7:0] got_b;
    do_reset();
    pat_a   = 8'($urandom);
    pat_b   = 8'($urandom);
    reset_n = 1'b1;
    enable  = 1'b1;
    fv_cnt = 0; fv_rel = -1; rise_cnt = 0; busy_cnt = 0; prev_l = 1'b0; got_b = '0;
    for (int rel = 1; rel <= FRAME_CLKS + 1 + 200; rel++) begin
      @(negedge clk_old);
      if (rel == 3) enable = 1'b0;
      if (frame_valid) begin
        fv_cnt++;
        fv_rel = rel;
        got_b  = btn_b;
      end
      if (latch && !prev_l) rise_cnt++;
      prev_l = latch;
      if (busy) busy_cnt++;
    end
    checks++;
    if ((fv_cnt != 1) || (fv_rel != FRAME_CLKS + 1) || (got_b !== pat_b)) begin
      errors++;
      $display("FAIL endrop_commit: fv=%0d at %0d btn_b=%h want 1 at %0d %h", fv_cnt, fv_rel,
               got_b, FRAME_CLKS + 1, pat_b);
    end
    checks++;
    if ((rise_cnt != 1) || (busy_cnt != FRAME_CLKS)) begin
      errors++;
      $display("FAIL endrop_idle: rises=%0d busy=%0d want 1 and %0d", rise_cnt, busy_cnt,
               FRAME_CLKS);
    end
  endtask

  task automatic test_collision();
    int   rises[$];
    logic prev_l;
    do_reset();
    reset_n = 1'b1;
    enable  = 1'b1;
    prev_l  = 1'b0;
    for (int rel = 1; rel <= 2 * PERIOD_CLKS + 8; rel++) begin
      @(negedge clk_old);
      // Request lands on the same clock as the periodic expiry.
      poll_req = (rel == PERIOD_CLKS);
      if (latch && !prev_l) rises.push_back(rel);
      prev_l = latch;
    end
    poll_req = 1'b0;
    checks++;
    if ((rises.size() != 3) || (rises[1] != PERIOD_CLKS + 1) ||
        (rises[2] != 2 * PERIOD_CLKS + 1)) begin
      errors++;
      $display("FAIL collision_rises: got %p want '{1, %0d, %0d}", rises, PERIOD_CLKS + 1,
               2 * PERIOD_CLKS + 1);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_buttons();
    test_random_frames();
    test_single_poll();
    test_poll_mid_frame();
    test_reset_mid_frame();
    test_enable_drop();
    test_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
